// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//
// Receive-side byte FIFO between the Bluetooth UART serial receiver and the
// processor datapath. The receiver strobes bytes in, and the control unit pops
// them one at a time with a UART input instruction. The popped byte is held on
// rd_data for the 8-to-16 immediate extender path. The block reports fill
// level and a sticky overrun flag. It can optionally raise a watermark
// interrupt.
//
// Optional feature macro: UART_RX_WATERMARK_IRQ_EN
//   defined   -> irq is a registered level, high while count >= WATERMARK
//   undefined -> irq is tied low and no comparator is built
//
// Parameters
//   DEPTH       number of byte entries (power of two, >= 2)
//   WATERMARK   fill level at which irq asserts (1..DEPTH)
//
// Ports
//   clock        in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   rx_valid     in   one-cycle strobe, rx_data holds a received byte
//   rx_data      in   received byte
//   rx_err       in   framing error on the current strobe (byte discarded)
//   rd_req       in   one-cycle pop request
//   flush        in   synchronous clear of contents and flags
//   clr_overrun  in   clears the sticky overrun flag
//   rd_data      out  last popped byte, held until the next successful pop
//   rd_valid     out  one-cycle strobe, rd_data updated this cycle
//   empty        out  count == 0
//   full         out  count == DEPTH
//   count        out  number of stored bytes
//   overrun      out  sticky, a byte was dropped because the FIFO was full
//   irq          out  watermark interrupt
// -----------------------------------------------------------------------------
module uart_rx_buffer #(
  parameter int DEPTH     = 16,
  parameter int WATERMARK = 8
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_err,
  input  logic                   rd_req,
  input  logic                   flush,
  input  logic                   clr_overrun,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Reject unsupported parameter values at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffer: DEPTH must be a power of two >= 2");
  end
  if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_watermark
    $error("uart_rx_buffer: WATERMARK must lie in 1..DEPTH");
  end

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_r;
  logic          full_r;
  logic [7:0]    rd_data_r;
  logic          rd_valid_r;
  logic          overrun_r;

  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [CW-1:0] count_nxt_s;

  // Accept/drop decisions and next fill level.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    drop_s      = 1'b0;
    count_nxt_s = count_r;

    pop_s  = rd_req && !empty_r;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_s = rx_valid && !rx_err && (!full_r || pop_s);
    drop_s = rx_valid && !rx_err && full_r && !pop_s;

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Byte storage. The memory has no reset, and flush leaves its contents alone.
  always_ff @(posedge clock) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Pointers, fill level, status flags and the registered read port.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (flush) begin
      // rd_data is intentionally retained across a flush.
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == {CW{1'b0}});
      full_r     <= (count_nxt_s == DEPTH_C);
      rd_valid_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        // When full with a simultaneous push, wr_ptr == rd_ptr. This reads the
        // old (oldest) byte because the write lands at the same edge.
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      // A new overrun event wins over a same-cycle clear.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;
  assign overrun  = overrun_r;

`ifdef UART_RX_WATERMARK_IRQ_EN
  localparam logic [CW-1:0] WATERMARK_C = CW'(WATERMARK);

  logic irq_r;

  // Watermark level, updated from the same next-count as the count register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      irq_r <= 1'b0;
    end else if (flush) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (count_nxt_s >= WATERMARK_C);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_buffer
//
// Directed bench for uart_rx_buffer (DEPTH = 16, WATERMARK = 8). Bytes that
// are expected to come out are queued when they are driven. Each rd_valid
// pulse pops the queue and compares the result with rd_data. Level and flag
// expectations are written out step by step.
// -----------------------------------------------------------------------------
module tb_uart_rx_buffer;

  localparam int DEPTH     = 16;
  localparam int WATERMARK = 8;
`ifdef UART_RX_WATERMARK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clock;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rd_req;
  logic       flush;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  uart_rx_buffer #(.DEPTH(DEPTH), .WATERMARK(WATERMARK)) dut (
    .clock       (clock),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .rd_req      (rd_req),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge and sample 1 time unit after the
  // rising edge. The rd_valid expectation is checked, and a pulse pops the queue.
  task automatic step(input string tag, input logic rv, input logic re, input logic [7:0] d,
                      input logic rq, input logic fl, input logic co, input logic exp_rv);
    logic [7:0] exp_b;
    @(negedge clock);
    rx_valid    = rv;
    rx_err      = re;
    rx_data     = d;
    rd_req      = rq;
    flush       = fl;
    clr_overrun = co;
    @(posedge clock);
    #1;
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(exp_rv));
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_unexpected_pop observed %0h expected no pop", tag, rd_data);
      end else begin
        exp_b = sb.pop_front();
        chk({tag, "_rd_data"}, 32'(rd_data), 32'(exp_b));
      end
    end
    rx_valid    = 1'b0;
    rx_err      = 1'b0;
    rd_req      = 1'b0;
    flush       = 1'b0;
    clr_overrun = 1'b0;
  endtask

  // Push DEPTH bytes base+i and check the level and watermark after each one.
  task automatic fill(input string tag, input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(base + 8'(i));
      step(tag, 1'b1, 1'b0, base + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, "_count"}, 32'(count), 32'(i + 1));
      chk({tag, "_irq"}, 32'(irq), 32'(IRQ_ON && (i + 1 >= WATERMARK)));
    end
    chk({tag, "_full"}, 32'(full), 32'd1);
  endtask

  // Pop n bytes back-to-back, starting from level 'from'.
  task automatic drain(input string tag, input int from, input int n);
    for (int k = 1; k <= n; k++) begin
      step(tag, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk({tag, "_count"}, 32'(count), 32'(from - k));
      chk({tag, "_irq"}, 32'(irq), 32'(IRQ_ON && (from - k >= WATERMARK)));
    end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    rd_req = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clock);
    rst = 1'b1;

    // Single byte round trip.
    sb.push_back(8'hA5);
    step("single_push", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_count1", 32'(count), 32'd1);
    chk("single_empty0", 32'(empty), 32'd0);
    step("single_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("single_count0", 32'(count), 32'd0);
    chk("single_empty1", 32'(empty), 32'd1);
    step("single_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_hold", 32'(rd_data), 32'hA5);

    // Fill to DEPTH, overflow, then drain in order with wrapping pointers.
    fill("fill0", 8'h00);
    step("ovf", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    drain("drain0", 16, 16);
    chk("drain0_empty", 32'(empty), 32'd1);
    chk("drain0_sb", 32'(sb.size()), 32'd0);
    chk("drain0_sticky", 32'(overrun), 32'd1);
    step("clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_overrun", 32'(overrun), 32'd0);

    // Full FIFO with a simultaneous push and pop.
    fill("fill1", 8'h20);
    sb.push_back(8'h55);
    step("full_pp", 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_pp_count", 32'(count), 32'd16);
    chk("full_pp_overrun", 32'(overrun), 32'd0);
    chk("full_pp_full", 32'(full), 32'd1);
    drain("drain1", 16, 16);
    chk("drain1_sb", 32'(sb.size()), 32'd0);
    step("empty_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_rd_hold", 32'(rd_data), 32'h55);
    chk("empty_rd_count", 32'(count), 32'd0);

    // Empty FIFO with a simultaneous push and pop: only the push lands.
    sb.push_back(8'h3C);
    step("empty_pp", 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_pp_count", 32'(count), 32'd1);
    step("empty_pp_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_pp_count0", 32'(count), 32'd0);

    // Framing errors never store and never raise overrun, even when full.
    fill("fill2", 8'h40);
    step("err_full", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_full_overrun", 32'(overrun), 32'd0);
    chk("err_full_count", 32'(count), 32'd16);
    step("ovf2", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf2_overrun", 32'(overrun), 32'd1);
    drain("drain2", 16, 11);
    step("err5", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err5_count", 32'(count), 32'd5);
    chk("err5_overrun", 32'(overrun), 32'd1);

    // Flush with 5 bytes stored and a read request that it overrides.
    step("flush", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_overrun", 32'(overrun), 32'd0);
    chk("flush_irq", 32'(irq), 32'd0);
    chk("flush_rd_data", 32'(rd_data), 32'h4A);
    sb.push_back(8'h99);
    step("post_flush_push", 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_flush_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // A same-cycle overrun event beats clr_overrun.
    fill("fill3", 8'h60);
    step("set_vs_clr", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_vs_clr_overrun", 32'(overrun), 32'd1);
    step("clr_only", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_only_overrun", 32'(overrun), 32'd0);
    step("flush_end", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.delete();
    chk("flush_end_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte FIFO between the Bluetooth UART serial receiver and the processor datapath. It captures each byte the receiver delivers and holds it until the control unit executes a UART input instruction. The popped byte is then presented to the 8-to-16 immediate extender path. The block decouples asynchronous host traffic from program timing, reports fill level and overrun to software, and optionally raises a watermark interrupt toward the interruption controller.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2
- WATERMARK, 8: fill level at which `irq` asserts; range 1..DEPTH
- clock  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: `rx_data` holds a received byte
- rx_data  in  8  received byte
- rx_err  in  1  framing error qualifier for the current `rx_valid`; the byte is discarded
- rd_req  in  1  one-cycle pop request from the control unit (UART input instruction)
- flush  in  1  synchronous clear of all contents and flags
- clr_overrun  in  1  clears the sticky `overrun` flag
- rd_data  out  8  last popped byte, held until the next successful pop
- rd_valid  out  1  one-cycle strobe: `rd_data` was updated this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  current number of stored bytes
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full
- irq  out  1  watermark interrupt (see Configuration)

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, plus a separate `count` register. Both pointers wrap modulo DEPTH naturally.
- Push happens when `rx_valid && !rx_err` and either (`count < DEPTH`) or a pop is accepted in the same cycle.
  - On push: `mem[wr_ptr] <= rx_data`, `wr_ptr++`.
- A push attempt while full with no pop accepted in the same cycle drops the byte and sets `overrun` to 1.
- `rx_valid && rx_err`: the byte is dropped, no state changes, and `overrun` is not affected.
- Pop is accepted when `rd_req && count > 0`.
  - On pop: `rd_data <= mem[rd_ptr]`, `rd_ptr++`, `rd_valid <= 1`.
- `rd_req` while empty is ignored: `rd_valid` stays 0 and `rd_data` holds its value. There is no bypass of a same-cycle push to the read port.
- Simultaneous accepted push and pop:
  - `count` is unchanged.
  - When full, the pop frees the slot, so the incoming byte is stored with no overrun.
  - When empty, only the push takes effect.
- `count` updates as +1 (push only), -1 (pop only), or unchanged.
- `overrun` control:
  - Set has priority over `clr_overrun` in the same cycle.
  - `clr_overrun` clears the flag otherwise.
- `flush` has priority over everything. It zeroes the pointers, `count`, `overrun`, and `rd_valid`. `rd_data` is retained and memory contents are not cleared.

## Timing
- Reset (`rst` = 0, asynchronous) sets the following; memory is not reset:
  - `wr_ptr` = `rd_ptr` = `count` = 0
  - `rd_data` = 8'h00, `rd_valid` = 0
  - `empty` = 1, `full` = 0, `overrun` = 0, `irq` = 0
- Push latency: a byte strobed in cycle N is counted in `count`/`empty` after edge N and can be popped by a `rd_req` in cycle N+1.
- Pop latency: for `rd_req` in cycle N, `rd_data`/`rd_valid` are valid after edge N, i.e. registered with 1-cycle latency. `rd_valid` is exactly one cycle wide.
- Back-to-back `rd_req` every cycle is supported and drains one byte per cycle.
- `empty`, `full`, and `count` are registered or derived from registered `count`, so they are glitch-free.
- Reset asserted mid-transfer aborts it immediately. A strobe coinciding with reset release is ignored.

## Configuration
- `UART_RX_WATERMARK_IRQ_EN` defined:
  - `irq` is a registered level, equal to 1 while `count >= WATERMARK`.
  - It updates with `count` (same edge) and clears through pops or `flush`.
- Undefined:
  - `irq` is tied to 0 and no comparator is built.

## Test plan
- Reset, then push 8'hA5, then `rd_req` on the next cycle: `rd_data` = 8'hA5, `rd_valid` pulses for 1 cycle, and the block returns to `empty` = 1, `count` = 0.
- Push 16 bytes 8'h00..8'h0F (DEPTH = 16): `full` = 1, `count` = 16. A 17th push (8'hFF) sets `overrun` = 1. Draining 16 pops returns 8'h00..8'h0F in order, and the pointers wrap to 0.
- FIFO full, then simultaneous push 8'h55 and `rd_req`: `rd_data` = oldest byte, `count` stays 16, `overrun` stays 0, and 8'h55 is popped last.
- FIFO empty, then simultaneous push 8'h3C and `rd_req`: `rd_valid` = 0, `count` = 1. The next `rd_req` returns 8'h3C.
- `rx_valid` with `rx_err` = 1 (8'h77): `count` unchanged and `overrun` unchanged. Then `flush` with 5 bytes stored: `count` = 0, `empty` = 1, `overrun` = 0. Then `clr_overrun` together with an overrun event in the same cycle: `overrun` = 1.
- With `UART_RX_WATERMARK_IRQ_EN` and WATERMARK = 8:
  - `irq` rises on the edge of the 8th push.
  - `irq` falls on the edge of the pop that takes `count` to 7.
  - Without the macro, `irq` = 0 throughout.
